// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and encodings for the next-PC unit
package pc_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      BR   = 2'd1,
      JMP  = 2'd2,
      JR   = 2'd3
   } sel_t;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - sequential-PC adder, jump target formation and redirect priority
module pc_target_sel
   import pc_pkg::*;
(
   input  logic [31:0] i_pc_cur,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_target,
   input  logic        i_jmp,
   input  logic [25:0] i_jmp_idx,
   input  logic        i_jr,
   input  logic [31:0] i_jr_target,
   output logic [31:0] o_pc_plus4,
   output logic [1:0]  o_sel,
   output logic [31:0] o_target_raw
);

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jmp_target;

   assign w_pc_plus4   = i_pc_cur + 32'd4;
   assign w_jmp_target = {w_pc_plus4[31:28], i_jmp_idx, 2'b00};
   assign o_pc_plus4   = w_pc_plus4;

   // Target is passed unmasked so the caller can detect misalignment.
   always_comb begin
      o_sel        = NONE;
      o_target_raw = w_pc_plus4;
      if (i_jr) begin
         o_sel        = JR;
         o_target_raw = i_jr_target;
      end else if (i_jmp) begin
         o_sel        = JMP;
         o_target_raw = w_jmp_target;
      end else if (i_br_taken) begin
         o_sel        = BR;
         o_target_raw = i_br_target;
      end
   end

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next-PC selection with stall-tolerant redirect holding
module next_pc_unit
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] PC_Cur,
   input  logic        Hold,
   input  logic        Br_Taken,
   input  logic [31:0] Br_Target,
   input  logic        Jmp,
   input  logic [25:0] Jmp_Idx,
   input  logic        Jr,
   input  logic [31:0] Jr_Target,
   output logic [31:0] Next_PC,
   output logic        PC_En,
   output logic        Flush_IF,
   output logic        Pend,
   output logic        Misalign
);

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pend_tgt;
   logic [31:0] w_pend_d;
   logic        r_misalign;
   logic        w_set_mis;
   logic [31:0] w_pc_plus4;
   logic [1:0]  w_sel;
   logic [31:0] w_target_raw;
   logic        w_redir;

   pc_target_sel u_sel (
      .i_pc_cur     (PC_Cur),
      .i_br_taken   (Br_Taken),
      .i_br_target  (Br_Target),
      .i_jmp        (Jmp),
      .i_jmp_idx    (Jmp_Idx),
      .i_jr         (Jr),
      .i_jr_target  (Jr_Target),
      .o_pc_plus4   (w_pc_plus4),
      .o_sel        (w_sel),
      .o_target_raw (w_target_raw)
   );

   assign w_redir = (w_sel != NONE);

   // Pending register keeps the raw target; alignment is enforced when applied.
   always_comb begin
      w_next_state = r_state;
      w_pend_d     = r_pend_tgt;
      w_set_mis    = 1'b0;
      Next_PC      = w_pc_plus4;
      PC_En        = 1'b1;
      Flush_IF     = 1'b0;
      if (Rst) begin
         Next_PC = RESET_VECTOR;
      end else begin
         case (r_state)
            RUN: begin
               if (Hold) begin
                  PC_En = 1'b0;
                  if (w_redir) begin
                     w_pend_d     = w_target_raw;
                     w_next_state = PEND;
                  end
               end else if (w_redir) begin
                  Next_PC   = {w_target_raw[31:2], 2'b00};
                  Flush_IF  = 1'b1;
                  w_set_mis = (w_target_raw[1:0] != 2'b00);
               end
            end
            PEND: begin
               if (Hold) begin
                  PC_En = 1'b0;
                  if (w_redir) begin
                     w_pend_d = w_target_raw;
                  end
               end else begin
                  Flush_IF     = 1'b1;
                  w_pend_d     = 32'd0;
                  w_next_state = RUN;
                  if (w_redir) begin
                     Next_PC   = {w_target_raw[31:2], 2'b00};
                     w_set_mis = (w_target_raw[1:0] != 2'b00);
                  end else begin
                     Next_PC   = {r_pend_tgt[31:2], 2'b00};
                     w_set_mis = (r_pend_tgt[1:0] != 2'b00);
                  end
               end
            end
            default: w_next_state = RUN;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state    <= RUN;
         r_pend_tgt <= 32'd0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_pend_tgt <= w_pend_d;
         r_misalign <= r_misalign | w_set_mis;
      end
   end

   assign Pend     = (r_state == PEND);
   assign Misalign = r_misalign;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed self-checking bench for next_pc_unit
module tb_next_pc_unit;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        Clk;
   logic        Rst;
   logic [31:0] PC_Cur;
   logic        Hold;
   logic        Br_Taken;
   logic [31:0] Br_Target;
   logic        Jmp;
   logic [25:0] Jmp_Idx;
   logic        Jr;
   logic [31:0] Jr_Target;
   logic [31:0] Next_PC;
   logic        PC_En;
   logic        Flush_IF;
   logic        Pend;
   logic        Misalign;

   int checks;
   int failures;

   next_pc_unit #(.RESET_VECTOR(RV)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .PC_Cur    (PC_Cur),
      .Hold      (Hold),
      .Br_Taken  (Br_Taken),
      .Br_Target (Br_Target),
      .Jmp       (Jmp),
      .Jmp_Idx   (Jmp_Idx),
      .Jr        (Jr),
      .Jr_Target (Jr_Target),
      .Next_PC   (Next_PC),
      .PC_En     (PC_En),
      .Flush_IF  (Flush_IF),
      .Pend      (Pend),
      .Misalign  (Misalign)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] pc;
      logic        br;
      logic [31:0] br_t;
      logic        jmp;
      logic [25:0] idx;
      logic        jr;
      logic [31:0] jr_t;
      logic [31:0] exp_pc;
      logic        exp_flush;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic hold,
                        input logic br, input logic [31:0] br_t,
                        input logic jmp, input logic [25:0] idx,
                        input logic jr, input logic [31:0] jr_t);
      @(negedge Clk);
      PC_Cur = pc; Hold = hold; Br_Taken = br; Br_Target = br_t;
      Jmp = jmp; Jmp_Idx = idx; Jr = jr; Jr_Target = jr_t;
      #1;
   endtask

   task automatic idle(input logic [31:0] pc, input logic hold);
      drive(pc, hold, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      vecs[0] = '{32'h0000_0010, 0, 32'h0,         0, 26'h0,       0, 32'h0,   32'h0000_0014, 0};
      vecs[1] = '{32'h0040_0000, 1, 32'h200,       1, 26'h3,       1, 32'h100, 32'h0000_0100, 1};
      vecs[2] = '{32'h0040_0000, 1, 32'h200,       1, 26'h3,       0, 32'h0,   32'h0000_000C, 1};
      vecs[3] = '{32'h0040_0000, 1, 32'h200,       0, 26'h0,       0, 32'h0,   32'h0000_0200, 1};
      vecs[4] = '{32'hFFFF_FFFC, 0, 32'h0,         0, 26'h0,       0, 32'h0,   32'h0000_0000, 0};
      vecs[5] = '{32'hF000_0000, 0, 32'h0,         1, 26'h3FF_FFFF, 0, 32'h0,  32'hFFFF_FFFC, 1};
      vecs[6] = '{32'hEFFF_FFFC, 0, 32'h0,         1, 26'h1,       0, 32'h0,   32'hF000_0004, 1};
      vecs[7] = '{32'h0000_1000, 1, 32'h200,       0, 26'h0,       1, 32'h300, 32'h0000_0300, 1};

      // Reset: vector driven even with a redirect present
      Rst = 1'b1;
      drive(32'h0000_0010, 1'b0, 1'b1, 32'h200, 1'b0, 26'd0, 1'b1, 32'h100);
      chk("rst_next_pc", Next_PC, RV);
      chk("rst_pc_en", {31'd0, PC_En}, 32'd1);
      chk("rst_flush", {31'd0, Flush_IF}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      idle(32'h0000_0010, 1'b0);
      chk("rst_pend", {31'd0, Pend}, 32'd0);
      chk("rst_misalign", {31'd0, Misalign}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].pc, 1'b0, vecs[i].br, vecs[i].br_t, vecs[i].jmp, vecs[i].idx,
               vecs[i].jr, vecs[i].jr_t);
         chk($sformatf("vec%0d_next_pc", i), Next_PC, vecs[i].exp_pc);
         chk($sformatf("vec%0d_pc_en", i), {31'd0, PC_En}, 32'd1);
         chk($sformatf("vec%0d_flush", i), {31'd0, Flush_IF}, {31'd0, vecs[i].exp_flush});
         chk($sformatf("vec%0d_pend", i), {31'd0, Pend}, 32'd0);
      end

      // Branch under a 3-cycle hold, then released
      for (int c = 0; c < 3; c++) begin
         drive(32'h0000_0040, 1'b1, 1'b1, 32'h200, 1'b0, 26'd0, 1'b0, 32'd0);
         chk($sformatf("hold%0d_pc_en", c), {31'd0, PC_En}, 32'd0);
         chk($sformatf("hold%0d_flush", c), {31'd0, Flush_IF}, 32'd0);
         chk($sformatf("hold%0d_pend", c), {31'd0, Pend}, (c == 0) ? 32'd0 : 32'd1);
      end
      idle(32'h0000_0040, 1'b0);
      chk("rel_next_pc", Next_PC, 32'h0000_0200);
      chk("rel_flush", {31'd0, Flush_IF}, 32'd1);
      chk("rel_pc_en", {31'd0, PC_En}, 32'd1);
      idle(32'h0000_0200, 1'b0);
      chk("rel_after_pend", {31'd0, Pend}, 32'd0);
      chk("rel_after_flush", {31'd0, Flush_IF}, 32'd0);
      chk("rel_after_next_pc", Next_PC, 32'h0000_0204);

      // New jump on release beats the pending branch
      drive(32'h0000_0040, 1'b1, 1'b1, 32'h200, 1'b0, 26'd0, 1'b0, 32'd0);
      drive(32'h1000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 26'h10, 1'b0, 32'd0);
      chk("pjmp_next_pc", Next_PC, 32'h1000_0040);
      chk("pjmp_flush", {31'd0, Flush_IF}, 32'd1);
      idle(32'h1000_0040, 1'b0);
      chk("pjmp_after_pend", {31'd0, Pend}, 32'd0);
      chk("pjmp_after_next_pc", Next_PC, 32'h1000_0044);

      // Redirect arriving during PEND overwrites the held target
      drive(32'h0000_0040, 1'b1, 1'b1, 32'h200, 1'b0, 26'd0, 1'b0, 32'd0);
      drive(32'h0000_0040, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h300);
      idle(32'h0000_0040, 1'b1);
      chk("ovr_pc_en", {31'd0, PC_En}, 32'd0);
      idle(32'h0000_0040, 1'b0);
      chk("ovr_next_pc", Next_PC, 32'h0000_0300);

      // Reset while pending drops the redirect without a later flush
      drive(32'h0000_0040, 1'b1, 1'b1, 32'h200, 1'b0, 26'd0, 1'b0, 32'd0);
      idle(32'h0000_0040, 1'b1);
      chk("prst_pend_before", {31'd0, Pend}, 32'd1);
      Rst = 1'b1;
      #1;
      chk("prst_next_pc", Next_PC, RV);
      chk("prst_flush", {31'd0, Flush_IF}, 32'd0);
      chk("prst_pc_en", {31'd0, PC_En}, 32'd1);
      @(negedge Clk);
      Rst = 1'b0;
      idle(32'h0000_0040, 1'b0);
      chk("prst_pend_after", {31'd0, Pend}, 32'd0);
      chk("prst_flush_after", {31'd0, Flush_IF}, 32'd0);
      chk("prst_next_pc_after", Next_PC, 32'h0000_0044);

      // Misaligned JR target: masked on Next_PC, sticky flag until reset
      drive(32'h0000_0044, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h103);
      chk("mis_next_pc", Next_PC, 32'h0000_0100);
      chk("mis_flag_before", {31'd0, Misalign}, 32'd0);
      idle(32'h0000_0100, 1'b0);
      chk("mis_flag_set", {31'd0, Misalign}, 32'd1);
      idle(32'h0000_0104, 1'b0);
      idle(32'h0000_0108, 1'b0);
      chk("mis_flag_sticky", {31'd0, Misalign}, 32'd1);
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      chk("mis_flag_cleared", {31'd0, Misalign}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, the value driven on Next_PC while Rst is high.
REQ-002 Clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Rst  input  1  synchronous, active-high reset; sampled only on the rising edge of Clk.
REQ-004 PC_Cur  input  32  current PC, taken from the PC register output.
REQ-005 Hold  input  1  stall request from the hazard unit; high means the PC must not advance.
REQ-006 Br_Taken  input  1  resolved conditional branch taken; Br_Target (input, 32) is its target.
REQ-007 Jmp  input  1  J/JAL in decode; Jmp_Idx (input, 26) is its instruction index.
REQ-008 Jr  input  1  JR/JALR in decode; Jr_Target (input, 32) is the register value.
REQ-009 Next_PC  output  32  value loaded into the PC register.
REQ-010 PC_En  output  1  PC register load enable; high means load Next_PC.
REQ-011 Flush_IF  output  1  one-cycle pulse; the IF/ID register discards the instruction it captures.
REQ-012 Pend  output  1  high while a redirect is held in the pending register.
REQ-013 Misalign  output  1  sticky flag; set when an applied target has bits [1:0] not equal to 00.

Function
REQ-014 PC_Plus4 shall equal PC_Cur + 4, computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-015 Jump target shall be {PC_Plus4[31:28], Jmp_Idx, 2'b00}.
REQ-016 Redirect priority shall be Jr > Jmp > Br_Taken.
REQ-017 Any target applied to Next_PC shall have bits [1:0] forced to 00.
REQ-018 The FSM shall have two states, RUN and PEND, encoded as 1'b0 and 1'b1.
REQ-019 RUN with Hold=0 and no redirect: Next_PC=PC_Plus4, PC_En=1, Flush_IF=0.
REQ-020 RUN with Hold=0 and a redirect: Next_PC=winning target, PC_En=1, Flush_IF=1, all in the same cycle (zero latency).
REQ-021 RUN with Hold=1: PC_En=0 and Flush_IF=0; if a redirect is present, latch the winning target into the pending register and go to PEND.
REQ-022 PEND with Hold=1: PC_En=0; a new redirect overwrites the pending target; the state stays PEND.
REQ-023 PEND with Hold=0 and no new redirect: Next_PC=pending target, PC_En=1, Flush_IF=1; go to RUN.
REQ-024 PEND with Hold=0 and a new redirect: the new target wins over the pending target; PC_En=1, Flush_IF=1; clear the pending register; go to RUN.
REQ-025 Pend shall be 1 exactly when state=PEND (registered output).
REQ-026 Misalign shall be set on the edge that applies a target with nonzero bits [1:0], and cleared only by Rst.
REQ-027 Next_PC and Flush_IF shall be combinational from inputs and state; state, pending target and Misalign shall be registered.

Reset
REQ-028 While Rst=1: Next_PC=RESET_VECTOR, PC_En=1, Flush_IF=0.
REQ-029 At a Rst edge: state becomes RUN, the pending register becomes 0, Pend=0 and Misalign=0.
REQ-030 Rst asserted in PEND shall discard the pending redirect; no Flush_IF pulse follows the deassertion of Rst.

Structure
REQ-031 A shared package pc_pkg shall hold the RESET_VECTOR default, the RUN/PEND state encoding and the redirect-select encoding (NONE, BR, JMP, JR).
REQ-032 Target formation and priority selection shall live in one combinational sub-module, pc_target_sel; next_pc_unit shall hold the FSM and the registers.

Verification
REQ-033 Scenario: PC_Cur=0x0000_0010, no redirect, Hold=0 -> Next_PC=0x14, PC_En=1, Flush_IF=0.
REQ-034 Scenario: PC_Cur=0x0040_0000, Jr=1 with Jr_Target=0x100, Jmp=1 with Jmp_Idx=0x3, and Br_Taken=1 -> Next_PC=0x100 and Flush_IF=1 (Jr wins).
REQ-035 Scenario: Hold=1 with Br_Target=0x200 for 3 cycles, then Hold=0 -> PC_En=0 and Pend=1 during the hold; then one cycle with Next_PC=0x200, Flush_IF=1, PC_En=1; Pend=0 on the next cycle.
REQ-036 Scenario: PEND holding 0x200, Hold=0, Jmp=1 with PC_Cur=0x1000_0000 and Jmp_Idx=0x10 -> Next_PC=0x1000_0040; the 0x200 target is dropped.
REQ-037 Scenario: PC_Cur=0xFFFF_FFFC, no redirect -> Next_PC=0x0000_0000.
REQ-038 Scenario: Rst pulsed while in PEND, and separately Jr_Target=0x103 applied -> after Rst, Pend=0 and Flush_IF stays 0; after the Jr, Next_PC=0x100 and Misalign=1 until the next Rst.
